// File: rtl/cnn_pool_pkg.sv
// ============================================================================
// Module   : cnn_pool_pkg
// Purpose  : Shared constants and helpers for the CNN pooling datapath:
//            default activation width, a signed max and a clog2 helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pool_pkg;

  // Default signed activation width used by the pooling stage
  localparam int DEFAULT_DATA_W = 22;

  // Widest activation the shared max helper can compare
  localparam int MAX_W = 64;

  // Signed maximum of two sign-extended operands
  function automatic logic signed [MAX_W-1:0] max_s(input logic signed [MAX_W-1:0] a,
                                                    input logic signed [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to index v items; never returns less than 1
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/max_pool_stream_if.sv
// ============================================================================
// Module   : max_pool_stream_if
// Purpose  : Pixel-in / pooled-value-out valid-ready bundle for the
//            max-pooling stage. slave = pooling block, master = its peer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface max_pool_stream_if
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/pool_line_buf.sv
// ============================================================================
// Module   : pool_line_buf
// Purpose  : One partial vertical maximum per horizontal window slot.
//            Synchronous write, combinational read, same address. Not reset:
//            the first row of every window band writes a slot before it is
//            ever read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_line_buf #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 12,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Store the running column-band maximum for the addressed slot
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  assign rd_data = mem[addr];

endmodule

`default_nettype wire

// File: rtl/max_pool_stream.sv
// ============================================================================
// Module   : max_pool_stream
// Purpose  : Streaming POOLxPOOL non-overlapping max pooling over a raster
//            image, one pixel per cycle, valid/ready on both sides.
//            Optional macro MAX_POOL_RELU_EN clamps negative results to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max_pool_stream
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24,
  parameter int POOL   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  max_pool_stream_if.slave  bus
);

  localparam int SLOTS = IMG_W / POOL;
  localparam int COL_W = clog2(IMG_W);
  localparam int ROW_W = clog2(IMG_H);
  localparam int K_W   = clog2(POOL);
  localparam int S_W   = clog2(SLOTS);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(POOL - 1);

  typedef logic signed [DATA_W-1:0] data_t;

  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2 || DATA_W > MAX_W)
  begin : g_bad_cfg
    $error("max_pool_stream: IMG_W/IMG_H must be multiples of POOL, POOL >= 2");
  end

  // Signed max of two activations, via the shared wide comparator
  function automatic data_t pick_max(input data_t a, input data_t b);
    logic signed [MAX_W-1:0] wa;
    logic signed [MAX_W-1:0] wb;
    wa = MAX_W'(a);
    wb = MAX_W'(b);
    return (max_s(wa, wb) == wa) ? a : b;
  endfunction

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [K_W-1:0]   kx;
  logic [K_W-1:0]   ky;
  logic [S_W-1:0]   slot;
  data_t            hmax;
  logic             out_valid_q;
  data_t            out_data_q;
  logic             out_last_q;

  logic  accept;
  logic  kx_last;
  logic  ky_last;
  logic  col_last;
  logic  row_last;
  logic  lb_wr;
  logic  load;
  data_t h_next;
  data_t v_next;
  data_t lb_rd;
  data_t result;

  // Input is held off whenever a result is waiting and downstream is not taking it
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign kx_last  = (kx == K_LAST);
  assign ky_last  = (ky == K_LAST);
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Horizontal max restarts at each window's first column
  assign h_next = (kx == '0) ? bus.in_data : pick_max(hmax, bus.in_data);
  // Vertical merge with the slot's partial max, except on the band's first row
  assign v_next = (ky == '0) ? h_next : pick_max(lb_rd, h_next);

  assign lb_wr = accept && kx_last && !ky_last;
  assign load  = accept && kx_last && ky_last;

`ifdef MAX_POOL_RELU_EN
  assign result = v_next[DATA_W-1] ? '0 : v_next;
`else
  assign result = v_next;
`endif

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SLOTS),
    .ADDR_W (S_W)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr),
    .addr    (slot),
    .wr_data (v_next),
    .rd_data (lb_rd)
  );

  // Raster position counters; row and frame wrap without idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      kx   <= '0;
      ky   <= '0;
      slot <= '0;
    end else if (accept) begin
      kx <= kx_last ? '0 : kx + K_W'(1);
      if (col_last) begin
        col  <= '0;
        slot <= '0;
        ky   <= ky_last ? '0 : ky + K_W'(1);
        row  <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
        if (kx_last) slot <= slot + S_W'(1);
      end
    end
  end

  // Running horizontal maximum within the current window row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hmax <= '0;
    else if (accept) hmax <= h_next;
  end

  // Output register: load on window completion, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= result;
      out_last_q  <= row_last && col_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_stream.sv
// ============================================================================
// Module   : tb_max_pool_stream
// Purpose  : Scoreboard bench for max_pool_stream: a 4x4/POOL=2 instance and
//            a 6x6/POOL=3 instance, expected windows computed from whole frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max_pool_stream;

  localparam int DW = 22;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  max_pool_stream_if #(.DATA_W(DW)) ifa ();
  max_pool_stream_if #(.DATA_W(DW)) ifb ();

  max_pool_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4), .POOL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  max_pool_stream #(.DATA_W(DW), .IMG_W(6), .IMG_H(6), .POOL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  int   in_q_a[$];
  int   in_q_b[$];
  exp_t exp_q_a[$];
  exp_t exp_q_b[$];

  int n_checks = 0;
  int n_errors = 0;
  bit acc_a = 1'b0;
  bit acc_b = 1'b0;
  int n_acc_a = 0;
  int hold_a = 0;
  bit stall_arm_a = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(4194303, 0)) - 2097152;
  endfunction

  // Queue a frame's pixels and push its expected pooled values
  task automatic send_frame(input bit sel, input int w, input int h, input int p, input int px[]);
    exp_t e;
    int m;
    for (int i = 0; i < w * h; i++) begin
      if (sel) in_q_b.push_back(px[i]);
      else     in_q_a.push_back(px[i]);
    end
    for (int wy = 0; wy < h / p; wy++) begin
      for (int wx = 0; wx < w / p; wx++) begin
        m = px[wy * p * w + wx * p];
        for (int dy = 0; dy < p; dy++)
          for (int dx = 0; dx < p; dx++)
            if (px[(wy * p + dy) * w + wx * p + dx] > m) m = px[(wy * p + dy) * w + wx * p + dx];
`ifdef MAX_POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        e.data = m;
        e.last = (wy == h / p - 1) && (wx == w / p - 1);
        if (sel) exp_q_b.push_back(e);
        else     exp_q_a.push_back(e);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((in_q_a.size() > 0 || exp_q_a.size() > 0 || in_q_b.size() > 0 ||
            exp_q_b.size() > 0 || hold_a > 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq("idle_timeout", int'(t >= budget), 0);
    repeat (2) @(negedge clk);
    check_eq("a_no_extra_out", int'(ifa.out_valid), 0);
    check_eq("b_no_extra_out", int'(ifb.out_valid), 0);
  endtask

  // Driver and monitor for instance A (with optional output stall)
  initial begin
    ifa.in_valid  = 1'b0;
    ifa.in_data   = '0;
    ifa.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (acc_a) begin
        if (in_q_a.size() > 0) void'(in_q_a.pop_front());
        n_acc_a++;
      end
      if (hold_a > 0) begin
        ifa.out_ready = 1'b0;
        hold_a--;
      end else if (stall_arm_a && ifa.out_valid) begin
        stall_arm_a   = 1'b0;
        hold_a        = 4;
        ifa.out_ready = 1'b0;
      end else begin
        ifa.out_ready = 1'b1;
      end
      if (rst_n && in_q_a.size() > 0) begin
        ifa.in_valid = 1'b1;
        ifa.in_data  = DW'(in_q_a[0]);
      end else begin
        ifa.in_valid = 1'b0;
      end
      #1;
      acc_a = ifa.in_valid && ifa.in_ready;
      if (ifa.out_valid) begin
        if (exp_q_a.size() == 0) begin
          check_eq("a_unexpected_out", 1, 0);
        end else begin
          check_eq("a_data", ifa.out_data, exp_q_a[0].data);
          check_eq("a_last", int'(ifa.out_last), int'(exp_q_a[0].last));
          if (ifa.out_ready) void'(exp_q_a.pop_front());
          else check_eq("a_stall_in_ready", int'(ifa.in_ready), 0);
        end
      end
      if (ifa.in_valid && ifa.out_ready) check_eq("a_in_ready", int'(ifa.in_ready), 1);
    end
  end

  // Driver and monitor for instance B (downstream always ready)
  initial begin
    ifb.in_valid  = 1'b0;
    ifb.in_data   = '0;
    ifb.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (acc_b && in_q_b.size() > 0) void'(in_q_b.pop_front());
      if (rst_n && in_q_b.size() > 0) begin
        ifb.in_valid = 1'b1;
        ifb.in_data  = DW'(in_q_b[0]);
      end else begin
        ifb.in_valid = 1'b0;
      end
      #1;
      acc_b = ifb.in_valid && ifb.in_ready;
      if (ifb.out_valid) begin
        if (exp_q_b.size() == 0) begin
          check_eq("b_unexpected_out", 1, 0);
        end else begin
          check_eq("b_data", ifb.out_data, exp_q_b[0].data);
          check_eq("b_last", int'(ifb.out_last), int'(exp_q_b[0].last));
          void'(exp_q_b.pop_front());
        end
      end
      if (ifb.in_valid) check_eq("b_in_ready", int'(ifb.in_ready), 1);
    end
  end

  initial begin : main
    int ramp[];
    int b_img[];
    int f[];
    int base;
    int t;

    ramp = new[16];
    foreach (ramp[i]) ramp[i] = i + 1;
    b_img = new[36];
    foreach (b_img[i]) b_img[i] = i;
    f = new[16];

    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_out_valid", int'(ifa.out_valid), 0);
    check_eq("rst_out_data", ifa.out_data, 0);
    check_eq("rst_out_last", int'(ifa.out_last), 0);
    check_eq("rst_in_ready", int'(ifa.in_ready), 1);
    check_eq("rst_b_out_valid", int'(ifb.out_valid), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Ramp frame on A; two back-to-back frames on B
    send_frame(1'b0, 4, 4, 2, ramp);
    send_frame(1'b1, 6, 6, 3, b_img);
    send_frame(1'b1, 6, 6, 3, b_img);
    wait_idle(400);

    // Uniform negative frame
    foreach (f[i]) f[i] = -5;
    send_frame(1'b0, 4, 4, 2, f);
    wait_idle(200);

    // Signed extremes in the first window
    foreach (f[i]) f[i] = rnd_s();
    f[0] = -2097152;
    f[1] = 2097151;
    f[4] = -1;
    f[5] = 0;
    send_frame(1'b0, 4, 4, 2, f);
    wait_idle(200);

    // Downstream stall after the first output
    stall_arm_a = 1'b1;
    send_frame(1'b0, 4, 4, 2, ramp);
    wait_idle(300);

    // Random frames on both instances
    foreach (f[i]) f[i] = rnd_s();
    send_frame(1'b0, 4, 4, 2, f);
    foreach (b_img[i]) b_img[i] = rnd_s();
    send_frame(1'b1, 6, 6, 3, b_img);
    wait_idle(300);

    // Reset after seven pixels of a frame, then a clean frame
    base = n_acc_a;
    send_frame(1'b0, 4, 4, 2, ramp);
    t = 0;
    while (n_acc_a < base + 7 && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    check_eq("rst_wait_timeout", int'(t >= 200), 0);
    rst_n = 1'b0;
    in_q_a.delete();
    exp_q_a.delete();
    acc_a = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(ifa.out_valid), 0);
    check_eq("midrst_out_data", ifa.out_data, 0);
    check_eq("midrst_out_last", int'(ifa.out_last), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_frame(1'b0, 4, 4, 2, ramp);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/max_pool_stream.md
# max_pool_stream

Streaming, parametrised POOL×POOL max-pooling stage for the CNN datapath. It accepts one signed activation per cycle in raster order over a valid/ready handshake and emits one pooled value per non-overlapping window. It sits between the convolution/activation output and the next layer's input buffer. It generalises the fixed 4-input, single-shot pooling unit to arbitrary window size and image width, with line buffering and backpressure.

## Interface
- DATA_W, 22: signed activation width in bits.
- IMG_W, 24: input row length in pixels; must be a multiple of POOL.
- IMG_H, 24: input rows per frame; must be a multiple of POOL.
- POOL, 2: window size and stride (square, non-overlapping), ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  signed input pixel, raster order.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_W  signed pooled result.
- out_last  out  1  marks the final pooled value of a frame.

## Operation
- An input beat is accepted when in_valid && in_ready. An output beat is accepted when out_valid && out_ready.
- Counters: col (0..IMG_W-1), row (0..IMG_H-1), kx = col mod POOL, ky = row mod POOL. All advance only on accepted input beats. col wraps to 0 at IMG_W-1 and increments row. row wraps to 0 at IMG_H-1, and the next frame starts with no idle cycle.
- Horizontal accumulator hmax: when kx==0, load in_data; otherwise hmax = max(hmax, in_data). All comparisons are signed.
- At kx==POOL-1 the horizontal result h = max(hmax, in_data) is complete, with slot index s = col/POOL:
  - ky==0: linebuf[s] = h.
  - 0<ky<POOL-1: linebuf[s] = max(linebuf[s], h).
  - ky==POOL-1: result = max(linebuf[s], h) is loaded into the output register and out_valid is set. out_last is set iff row==IMG_H-1 and col==IMG_W-1.
- linebuf holds IMG_W/POOL entries of DATA_W bits and is not reset; the ky==0 write always initialises an entry before it is read.
- in_ready = !out_valid || out_ready, combinational. The input is stalled whenever an unaccepted output is pending, even if the next pixel would not produce an output.
- Output register: out_valid clears on an output accept with no new result loaded. Accept and load in the same cycle keeps out_valid at 1 with the new data.
- Elaboration fails if IMG_W%POOL != 0, IMG_H%POOL != 0, or POOL<2.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, col=row=0, hmax=0. in_ready=1 while in reset release.
- Latency: out_valid rises on the clock edge that accepts the window's last pixel, so the result is visible in the following cycle.
- Throughput: 1 pixel/cycle with out_ready held high. There are no bubbles at row or frame boundaries.
- Reset asserted mid-frame aborts the partial window and frame. Any pending output is dropped, and the first pixel accepted after reset is pixel (0,0).
- out_data and out_last hold stable while out_valid && !out_ready.

## Configuration
- MAX_POOL_RELU_EN defined: the value loaded into the output register is clamped to 0 if negative (fused ReLU). Comparisons inside the window remain signed on raw data.
- Not defined: out_data is the raw signed maximum, and negative results pass through.

## Structure
- Shared package cnn_pool_pkg: default DATA_W, a signed-max function max_s(a,b), and a clog2 helper for counter widths. Counter widths are derived from IMG_W, IMG_H and POOL.
- One sub-module: pool_line_buf, an IMG_W/POOL × DATA_W register array with one synchronous write port and one combinational read port at address s.

## Test plan
- IMG_W=IMG_H=4, POOL=2, inputs 1..16 raster, out_ready=1 → outputs 6, 8, 14, 16; out_last only on 16; in_ready stays 1 throughout.
- Same image with all pixels −5, macro undefined → four outputs of −5. With MAX_POOL_RELU_EN defined → four outputs of 0.
- Window {−2097152, 2097151, −1, 0} → 2097151, which checks signed compare at DATA_W extremes.
- out_ready held 0 for 5 cycles after the first output → out_data=6 held stable and in_ready=0. After release the remaining 8, 14, 16 arrive in order with no loss.
- POOL=3, IMG_W=IMG_H=6, input value = row*6+col → outputs 14, 17, 32, 35; two back-to-back frames continue without a gap.
- rst_n pulsed low after 7 pixels of frame 1 → outputs clear immediately. A fresh 1..16 frame after release yields exactly 6, 8, 14, 16.
